// File: rtl/arp_ctrl.sv
// ARP control sequencer: resolves IPv4 -> MAC through a one-entry cache with
// timeout/retry, answers peer ARP requests and shares the single ARP tx port
// between outgoing requests and pending replies.
module arp_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 1_250_000,
   parameter int unsigned MAX_TRIES   = 3,
   parameter logic [47:0] BCAST_MAC   = 48'hFFFF_FFFF_FFFF
) (
   input  logic        gmii_clk,
   input  logic        sys_rst_n,
   input  logic        resolve_req,
   input  logic [31:0] resolve_ip,
   output logic        resolve_done,
   output logic        resolve_ok,
   output logic [47:0] resolved_mac,
   output logic        busy,
   output logic        arp_tx_en,
   output logic        arp_tx_type,
   output logic [47:0] des_mac,
   output logic [31:0] des_ip,
   input  logic        tx_done,
   input  logic        arp_rx_done,
   input  logic        arp_rx_type,
   input  logic [47:0] rx_src_mac,
   input  logic [31:0] rx_src_ip
);

   localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);

   typedef enum logic [2:0] {
      IDLE, TX_REQ, WAIT_TXREQ, WAIT_RPLY, TX_RPLY, WAIT_TXRPLY
   } state_t;

   state_t            state, state_nxt, ret, ret_nxt;
   logic              pend_rply;
   logic [47:0]       pend_mac;
   logic [31:0]       pend_ip;
   logic              clr_pend;
   logic              cache_vld, cache_vld_nxt;
   logic [31:0]       cache_ip, cache_ip_nxt;
   logic [47:0]       cache_mac_nxt;
   logic [31:0]       tgt_ip, tgt_ip_nxt;
   logic [TRY_W-1:0]  tries, tries_nxt;
   logic [TMR_W-1:0]  timer, timer_nxt;
   logic              hit_lat, hit_lat_nxt;
   logic [47:0]       hit_mac, hit_mac_nxt;
   logic              done_nxt, ok_nxt, tx_en_nxt, tx_type_nxt;
   logic [47:0]       des_mac_nxt;
   logic [31:0]       des_ip_nxt;

   logic rx_match_c;
   logic pend_cap_c;
   assign rx_match_c = arp_rx_done && arp_rx_type && (rx_src_ip == tgt_ip);
   assign pend_cap_c = arp_rx_done && !arp_rx_type;

   // Next-state, datapath and output decode
   always_comb begin
      state_nxt     = state;
      ret_nxt       = ret;
      tgt_ip_nxt    = tgt_ip;
      tries_nxt     = tries;
      timer_nxt     = timer;
      cache_vld_nxt = cache_vld;
      cache_ip_nxt  = cache_ip;
      cache_mac_nxt = resolved_mac;
      hit_lat_nxt   = hit_lat;
      hit_mac_nxt   = hit_mac;
      done_nxt      = 1'b0;
      ok_nxt        = 1'b0;
      tx_en_nxt     = 1'b0;
      tx_type_nxt   = arp_tx_type;
      des_mac_nxt   = des_mac;
      des_ip_nxt    = des_ip;
      clr_pend      = 1'b0;

      case (state)
         IDLE: begin
            if (pend_rply) begin
               state_nxt = TX_RPLY;
               ret_nxt   = IDLE;
            end else if (resolve_req) begin
               if (cache_vld && (resolve_ip == cache_ip)) begin
                  done_nxt = 1'b1;
                  ok_nxt   = 1'b1;
               end else begin
                  tgt_ip_nxt  = resolve_ip;
                  tries_nxt   = '0;
                  hit_lat_nxt = 1'b0;
                  state_nxt   = TX_REQ;
               end
            end
         end
         TX_REQ: begin
            tx_en_nxt   = 1'b1;
            tx_type_nxt = 1'b0;
            des_mac_nxt = BCAST_MAC;
            des_ip_nxt  = tgt_ip;
            tries_nxt   = tries + TRY_W'(1);
            state_nxt   = WAIT_TXREQ;
         end
         WAIT_TXREQ: begin
            if (tx_done) begin
               timer_nxt = '0;
               state_nxt = WAIT_RPLY;
            end
         end
         WAIT_RPLY: begin
            if (timer != TMR_LAST) timer_nxt = timer + TMR_W'(1);
            if (rx_match_c || hit_lat) begin
               cache_vld_nxt = 1'b1;
               cache_ip_nxt  = tgt_ip;
               cache_mac_nxt = rx_match_c ? rx_src_mac : hit_mac;
               hit_lat_nxt   = 1'b0;
               done_nxt      = 1'b1;
               ok_nxt        = 1'b1;
               state_nxt     = IDLE;
            end else if (pend_rply) begin
               state_nxt = TX_RPLY;
               ret_nxt   = WAIT_RPLY;
            end else if (timer == TMR_LAST) begin
               if (tries < TRY_MAX) begin
                  state_nxt = TX_REQ;
               end else begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         TX_RPLY: begin
            tx_en_nxt = 1'b1;
            state_nxt = WAIT_TXRPLY;
         end
         WAIT_TXRPLY: begin
            if (tx_done) state_nxt = ret;
         end
         default: state_nxt = IDLE;
      endcase

      // A resolution in progress keeps its clock running and remembers a matching reply
      if (((state == TX_RPLY) || (state == WAIT_TXRPLY)) && (ret == WAIT_RPLY)) begin
         if (timer != TMR_LAST) timer_nxt = timer + TMR_W'(1);
         if (rx_match_c) begin
            hit_lat_nxt = 1'b1;
            hit_mac_nxt = rx_src_mac;
         end
      end

      // Reply frame fields are taken from the pending slot as it is consumed
      if ((state_nxt == TX_RPLY) && (state != TX_RPLY)) begin
         clr_pend    = 1'b1;
         tx_type_nxt = 1'b1;
         des_mac_nxt = pend_mac;
         des_ip_nxt  = pend_ip;
      end
   end

   // State register
   always_ff @(posedge gmii_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= IDLE;
         ret   <= IDLE;
      end else begin
         state <= state_nxt;
         ret   <= ret_nxt;
      end
   end

   // Pending-reply slot; a fresh capture beats the clear
   always_ff @(posedge gmii_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pend_rply <= 1'b0;
         pend_mac  <= '0;
         pend_ip   <= '0;
      end else if (pend_cap_c) begin
         pend_rply <= 1'b1;
         pend_mac  <= rx_src_mac;
         pend_ip   <= rx_src_ip;
      end else if (clr_pend) begin
         pend_rply <= 1'b0;
      end
   end

   // Resolution datapath: target, retries, timer, cache
   always_ff @(posedge gmii_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tgt_ip    <= '0;
         tries     <= '0;
         timer     <= '0;
         cache_vld <= 1'b0;
         cache_ip  <= '0;
         hit_lat   <= 1'b0;
         hit_mac   <= '0;
      end else begin
         tgt_ip    <= tgt_ip_nxt;
         tries     <= tries_nxt;
         timer     <= timer_nxt;
         cache_vld <= cache_vld_nxt;
         cache_ip  <= cache_ip_nxt;
         hit_lat   <= hit_lat_nxt;
         hit_mac   <= hit_mac_nxt;
      end
   end

   // Registered outputs
   always_ff @(posedge gmii_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         resolve_done <= 1'b0;
         resolve_ok   <= 1'b0;
         resolved_mac <= '0;
         busy         <= 1'b0;
         arp_tx_en    <= 1'b0;
         arp_tx_type  <= 1'b0;
         des_mac      <= '0;
         des_ip       <= '0;
      end else begin
         resolve_done <= done_nxt;
         resolve_ok   <= ok_nxt;
         resolved_mac <= cache_mac_nxt;
         busy         <= (state_nxt != IDLE);
         arp_tx_en    <= tx_en_nxt;
         arp_tx_type  <= tx_type_nxt;
         des_mac      <= des_mac_nxt;
         des_ip       <= des_ip_nxt;
      end
   end

endmodule

// File: tb/tb_arp_ctrl.sv
// Self-checking bench for arp_ctrl with a loopback ARP engine and a
// transaction-level model of the resolver cache.
module tb_arp_ctrl;

   localparam int unsigned T    = 1000;
   localparam int unsigned MAXT = 3;
   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

   logic        gmii_clk;
   logic        sys_rst_n;
   logic        resolve_req;
   logic [31:0] resolve_ip;
   logic        resolve_done;
   logic        resolve_ok;
   logic [47:0] resolved_mac;
   logic        busy;
   logic        arp_tx_en;
   logic        arp_tx_type;
   logic [47:0] des_mac;
   logic [31:0] des_ip;
   logic        tx_done;
   logic        arp_rx_done;
   logic        arp_rx_type;
   logic [47:0] rx_src_mac;
   logic [31:0] rx_src_ip;

   arp_ctrl #(.TIMEOUT_CYC(T), .MAX_TRIES(MAXT), .BCAST_MAC(BCAST)) dut (
      .gmii_clk(gmii_clk), .sys_rst_n(sys_rst_n),
      .resolve_req(resolve_req), .resolve_ip(resolve_ip),
      .resolve_done(resolve_done), .resolve_ok(resolve_ok), .resolved_mac(resolved_mac),
      .busy(busy), .arp_tx_en(arp_tx_en), .arp_tx_type(arp_tx_type),
      .des_mac(des_mac), .des_ip(des_ip), .tx_done(tx_done),
      .arp_rx_done(arp_rx_done), .arp_rx_type(arp_rx_type),
      .rx_src_mac(rx_src_mac), .rx_src_ip(rx_src_ip)
   );

   typedef struct {
      logic        typ;
      logic [47:0] mac;
      logic [31:0] ip;
      int unsigned cyc;
   } frame_t;

   frame_t      frames[$];
   int unsigned cyc = 0;
   int unsigned done_cnt = 0;
   int unsigned tx_lat = 5;
   int unsigned tx_cnt = 0;
   int unsigned n_cmp = 0;
   int unsigned n_fail = 0;

   // Resolver model: last successful resolution
   logic        m_vld = 1'b0;
   logic [31:0] m_ip  = '0;
   logic [47:0] m_mac = '0;

   initial gmii_clk = 1'b0;
   always #4 gmii_clk = ~gmii_clk;

   always @(posedge gmii_clk) cyc <= cyc + 1;

   always @(negedge gmii_clk) if (resolve_done === 1'b1) done_cnt <= done_cnt + 1;

   // Loopback ARP engine: logs each frame, returns tx_done tx_lat cycles later
   initial begin
      tx_done = 1'b0;
      forever begin
         @(negedge gmii_clk);
         tx_done = 1'b0;
         if (sys_rst_n !== 1'b1) begin
            tx_cnt = 0;
         end else if (arp_tx_en === 1'b1) begin
            frames.push_back('{typ: arp_tx_type, mac: des_mac, ip: des_ip, cyc: cyc});
            tx_cnt = tx_lat;
         end else if (tx_cnt != 0) begin
            tx_cnt = tx_cnt - 1;
            if (tx_cnt == 0) tx_done = 1'b1;
         end
      end
   end

   initial begin
      #(8 * 90_000);
      $display("FAIL watchdog: simulation exceeded 90000 cycles, required to finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge gmii_clk);
   endtask

   task automatic pulse_req(input logic [31:0] ip, output int unsigned c);
      resolve_ip  = ip;
      resolve_req = 1'b1;
      c = cyc;
      tick();
      resolve_req = 1'b0;
   endtask

   task automatic send_rx(input logic typ, input logic [47:0] mac, input logic [31:0] ip,
                          output int unsigned c);
      arp_rx_done = 1'b1;
      arp_rx_type = typ;
      rx_src_mac  = mac;
      rx_src_ip   = ip;
      c = cyc;
      tick();
      arp_rx_done = 1'b0;
   endtask

   task automatic wait_tx(input int budget, output int unsigned c);
      bit seen = 0;
      c = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (arp_tx_en === 1'b1) begin seen = 1; c = cyc; end
         else tick();
      end
   endtask

   task automatic wait_done(input int budget, output int unsigned c);
      bit seen = 0;
      c = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (resolve_done === 1'b1) begin seen = 1; c = cyc; end
         else tick();
      end
   endtask

   function automatic logic [31:0] rand_ip();
      return {8'd10, 24'($urandom)};
   endfunction

   function automatic logic [47:0] rand_mac();
      return {8'h02, 40'({$urandom, $urandom})};
   endfunction

   task automatic test_reset();
      sys_rst_n = 1'b0;
      tick(3);
      n_cmp++;
      if ({resolve_done, resolve_ok, resolved_mac, busy, arp_tx_en, arp_tx_type, des_mac, des_ip} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %0h required 0",
                  {resolve_done, resolve_ok, resolved_mac, busy, arp_tx_en, arp_tx_type, des_mac, des_ip});
      end
      sys_rst_n = 1'b1;
      tick(2);
      n_cmp++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b required 0", busy); end
   endtask

   task automatic test_miss_reply(input logic [31:0] ip, input logic [47:0] mac, input int rdly);
      int unsigned rq, t, x, dc, n0;
      n0 = frames.size();
      pulse_req(ip, rq);
      wait_tx(10, t);
      n_cmp++;
      if (t !== rq + 2) begin n_fail++; $display("FAIL req_latency: got cycle %0d required %0d", t, rq + 2); end
      n_cmp++;
      if ({arp_tx_type, des_mac, des_ip} !== {1'b0, BCAST, ip}) begin
         n_fail++;
         $display("FAIL req_frame: got %0h required %0h", {arp_tx_type, des_mac, des_ip}, {1'b0, BCAST, ip});
      end
      tick(tx_lat + rdly);
      send_rx(1'b1, mac, ip, x);
      wait_done(5, dc);
      n_cmp++;
      if (dc !== x + 1) begin n_fail++; $display("FAIL reply_done_latency: got cycle %0d required %0d", dc, x + 1); end
      n_cmp++;
      if ({resolve_ok, resolved_mac, busy} !== {1'b1, mac, 1'b0}) begin
         n_fail++;
         $display("FAIL reply_result: got %0h required %0h", {resolve_ok, resolved_mac, busy}, {1'b1, mac, 1'b0});
      end
      tick(3);
      n_cmp++;
      if (frames.size() - n0 !== 1) begin
         n_fail++; $display("FAIL reply_frame_count: got %0d required 1", frames.size() - n0);
      end
      m_vld = 1'b1; m_ip = ip; m_mac = mac;
   endtask

   task automatic test_no_reply(input logic [31:0] ip);
      int unsigned rq, dc, n0;
      int unsigned t[3];
      n0 = frames.size();
      pulse_req(ip, rq);
      for (int k = 0; k < 3; k++) begin
         wait_tx(T + tx_lat + 20, t[k]);
         tick();
      end
      wait_done(T + tx_lat + 20, dc);
      for (int k = 1; k < 3; k++) begin
         n_cmp++;
         if (t[k] - t[k-1] !== tx_lat + T + 2) begin
            n_fail++;
            $display("FAIL retry_spacing%0d: got %0d required %0d", k, t[k] - t[k-1], tx_lat + T + 2);
         end
      end
      n_cmp++;
      if (dc !== t[2] + tx_lat + T + 1) begin
         n_fail++; $display("FAIL fail_done_time: got cycle %0d required %0d", dc, t[2] + tx_lat + T + 1);
      end
      n_cmp++;
      if ({resolve_ok, resolved_mac, busy} !== {1'b0, m_mac, 1'b0}) begin
         n_fail++;
         $display("FAIL fail_result: got %0h required %0h", {resolve_ok, resolved_mac, busy}, {1'b0, m_mac, 1'b0});
      end
      tick(tx_lat + 10);
      n_cmp++;
      if (frames.size() - n0 !== 3) begin
         n_fail++; $display("FAIL fail_frame_count: got %0d required 3", frames.size() - n0);
      end
   endtask

   task automatic test_cache_hit(input logic [31:0] ip);
      int unsigned rq, n0;
      n0 = frames.size();
      pulse_req(ip, rq);
      n_cmp++;
      if ({resolve_done, resolve_ok, resolved_mac, busy} !== {1'b1, 1'b1, m_mac, 1'b0}) begin
         n_fail++;
         $display("FAIL hit_result: got %0h required %0h",
                  {resolve_done, resolve_ok, resolved_mac, busy}, {1'b1, 1'b1, m_mac, 1'b0});
      end
      tick(10);
      n_cmp++;
      if (frames.size() !== n0) begin n_fail++; $display("FAIL hit_no_tx: got %0d frames required 0", frames.size() - n0); end
   endtask

   task automatic test_peer_idle(input logic [47:0] mac, input logic [31:0] ip);
      int unsigned x, t, n0;
      n0 = frames.size();
      send_rx(1'b0, mac, ip, x);
      wait_tx(10, t);
      n_cmp++;
      if (t !== x + 3) begin n_fail++; $display("FAIL peer_latency: got cycle %0d required %0d", t, x + 3); end
      n_cmp++;
      if ({arp_tx_type, des_mac, des_ip} !== {1'b1, mac, ip}) begin
         n_fail++;
         $display("FAIL peer_frame: got %0h required %0h", {arp_tx_type, des_mac, des_ip}, {1'b1, mac, ip});
      end
      tick(tx_lat + 3);
      n_cmp++;
      if ({busy, 32'(frames.size() - n0)} !== {1'b0, 32'd1}) begin
         n_fail++; $display("FAIL peer_after: got busy=%0b frames=%0d required busy=0 frames=1", busy, frames.size() - n0);
      end
   endtask

   task automatic test_req_with_pend();
      int unsigned x, rq, n0, d0;
      logic typ0;
      logic [47:0] pm = rand_mac();
      logic [31:0] pip = rand_ip();
      n0 = frames.size();
      d0 = done_cnt;
      send_rx(1'b0, pm, pip, x);
      pulse_req(rand_ip(), rq);
      tick(tx_lat + 10);
      typ0 = (frames.size() > n0) ? frames[n0].typ : 1'bx;
      n_cmp++;
      if ({32'(frames.size() - n0), typ0} !== {32'd1, 1'b1}) begin
         n_fail++; $display("FAIL pend_drop_frames: got %0d frames type %0b required 1 frame type 1", frames.size() - n0, typ0);
      end
      n_cmp++;
      if (done_cnt !== d0) begin n_fail++; $display("FAIL pend_drop_done: got %0d pulses required 0", done_cnt - d0); end
   endtask

   task automatic test_peer_during_wait();
      int unsigned rq, t, x, y, dc, n0;
      logic [31:0] ip = rand_ip();
      logic [47:0] tmac = rand_mac();
      logic [47:0] pm = rand_mac();
      logic [31:0] pip = rand_ip();
      frame_t f;
      n0 = frames.size();
      pulse_req(ip, rq);
      wait_tx(10, t);
      tick(tx_lat + 5);
      send_rx(1'b0, pm, pip, x);
      tick(2);
      send_rx(1'b1, tmac, ip, y);
      wait_done(tx_lat + 20, dc);
      n_cmp++;
      if (dc !== y + tx_lat + 2) begin
         n_fail++; $display("FAIL latched_done_time: got cycle %0d required %0d", dc, y + tx_lat + 2);
      end
      n_cmp++;
      if ({resolve_ok, resolved_mac} !== {1'b1, tmac}) begin
         n_fail++; $display("FAIL latched_result: got %0h required %0h", {resolve_ok, resolved_mac}, {1'b1, tmac});
      end
      tick(3);
      f = '{typ: 1'bx, mac: 'x, ip: 'x, cyc: 0};
      if (frames.size() == n0 + 2) f = frames[n0 + 1];
      n_cmp++;
      if ({f.typ, f.mac, f.ip} !== {1'b1, pm, pip}) begin
         n_fail++; $display("FAIL wait_reply_frame: got %0h required %0h", {f.typ, f.mac, f.ip}, {1'b1, pm, pip});
      end
      m_vld = 1'b1; m_ip = ip; m_mac = tmac;
   endtask

   task automatic test_timer_cumulative();
      int unsigned rq, t0, tr, t1, x, y, dc;
      logic [31:0] ip = rand_ip();
      logic [47:0] tmac = rand_mac();
      logic [47:0] pm = rand_mac();
      logic [31:0] pip = rand_ip();
      pulse_req(ip, rq);
      wait_tx(10, t0);
      tick(tx_lat + 21);
      send_rx(1'b0, pm, pip, x);
      wait_tx(10, tr);
      n_cmp++;
      if ({arp_tx_type, des_mac, des_ip} !== {1'b1, pm, pip}) begin
         n_fail++; $display("FAIL cum_reply_frame: got %0h required %0h", {arp_tx_type, des_mac, des_ip}, {1'b1, pm, pip});
      end
      tick();
      wait_tx(T + tx_lat + 20, t1);
      n_cmp++;
      if (t1 - t0 !== tx_lat + T + 2) begin
         n_fail++; $display("FAIL cum_timer_spacing: got %0d required %0d", t1 - t0, tx_lat + T + 2);
      end
      tick(tx_lat + 3);
      send_rx(1'b1, tmac, ip, y);
      wait_done(5, dc);
      n_cmp++;
      if ({32'(dc), resolve_ok, resolved_mac} !== {32'(y + 1), 1'b1, tmac}) begin
         n_fail++;
         $display("FAIL cum_result: got cyc=%0d ok=%0b mac=%0h required cyc=%0d ok=1 mac=%0h", dc, resolve_ok, resolved_mac, y + 1, tmac);
      end
      m_vld = 1'b1; m_ip = ip; m_mac = tmac;
      tick(3);
   endtask

   task automatic test_ignore();
      int unsigned rq, rq2, t, x, y, dc, n0, d0;
      logic [31:0] ip = rand_ip();
      logic [47:0] tmac = rand_mac();
      n0 = frames.size();
      d0 = done_cnt;
      pulse_req(ip, rq);
      wait_tx(10, t);
      tick(tx_lat + 5);
      pulse_req(rand_ip(), rq2);
      tick(3);
      send_rx(1'b1, rand_mac(), ip ^ 32'h0000_0001, x);
      tick(3);
      n_cmp++;
      if ({32'(done_cnt - d0), busy} !== {32'd0, 1'b1}) begin
         n_fail++; $display("FAIL ignore_state: got done=%0d busy=%0b required done=0 busy=1", done_cnt - d0, busy);
      end
      send_rx(1'b1, tmac, ip, y);
      wait_done(5, dc);
      n_cmp++;
      if ({32'(dc), resolve_ok, resolved_mac} !== {32'(y + 1), 1'b1, tmac}) begin
         n_fail++;
         $display("FAIL ignore_result: got cyc=%0d ok=%0b mac=%0h required cyc=%0d ok=1 mac=%0h", dc, resolve_ok, resolved_mac, y + 1, tmac);
      end
      tick(3);
      n_cmp++;
      if (frames.size() - n0 !== 1) begin n_fail++; $display("FAIL ignore_frames: got %0d required 1", frames.size() - n0); end
      m_vld = 1'b1; m_ip = ip; m_mac = tmac;
   endtask

   task automatic test_reset_mid_frame(input logic [31:0] ip);
      int unsigned rq, t, d0;
      pulse_req(ip, rq);
      wait_tx(10, t);
      tick();
      sys_rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({resolve_done, resolve_ok, resolved_mac, busy, arp_tx_en, arp_tx_type, des_mac, des_ip} !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got %0h required 0",
                  {resolve_done, resolve_ok, resolved_mac, busy, arp_tx_en, arp_tx_type, des_mac, des_ip});
      end
      d0 = done_cnt;
      tick(4);
      sys_rst_n = 1'b1;
      tick(tx_lat + 10);
      n_cmp++;
      if ({32'(done_cnt - d0), busy} !== {32'd0, 1'b0}) begin
         n_fail++; $display("FAIL midreset_quiet: got done=%0d busy=%0b required done=0 busy=0", done_cnt - d0, busy);
      end
      m_vld = 1'b0; m_ip = '0; m_mac = '0;
   endtask

   task automatic test_random();
      logic [31:0] pool[3];
      int no_rply_left = 1;
      logic [31:0] ip;
      for (int i = 0; i < 3; i++) pool[i] = rand_ip();
      for (int it = 0; it < 10; it++) begin
         tx_lat = $urandom_range(3, 12);
         ip = pool[$urandom_range(0, 2)];
         if (m_vld && (ip == m_ip)) begin
            test_cache_hit(ip);
         end else if ((no_rply_left > 0) && ($urandom_range(0, 3) == 0)) begin
            no_rply_left--;
            test_no_reply(ip);
         end else begin
            test_miss_reply(ip, rand_mac(), int'($urandom_range(2, 60)));
         end
         if ($urandom_range(0, 2) == 0) test_peer_idle(rand_mac(), rand_ip());
      end
   endtask

   initial begin
      sys_rst_n   = 1'b0;
      resolve_req = 1'b0;
      resolve_ip  = '0;
      arp_rx_done = 1'b0;
      arp_rx_type = 1'b0;
      rx_src_mac  = '0;
      rx_src_ip   = '0;
      test_reset();
      test_miss_reply(32'hC0A8_0114, 48'h0200_0000_0020, 50);
      test_cache_hit(32'hC0A8_0114);
      test_no_reply(32'hC0A8_0115);
      test_peer_idle(48'h0200_0000_0030, 32'hC0A8_011E);
      test_req_with_pend();
      tx_lat = 7;
      test_peer_during_wait();
      test_timer_cumulative();
      test_ignore();
      test_reset_mid_frame(32'hC0A8_0114);
      test_miss_reply(32'hC0A8_0114, 48'h0200_0000_0021, 20);
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
